// File: rtl/dcache_direct_wt_if.sv
// dcache_direct_wt_if: memory-side bus of the data cache (line fill reads, single-word write-through writes)
interface dcache_direct_wt_if #(
  parameter int WORD_SIZE = 16
);
  logic                   mem_read;
  logic                   mem_write;
  logic [WORD_SIZE-1:0]   mem_addr;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic [4*WORD_SIZE-1:0] mem_rdata;
  logic                   mem_ack;
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_direct_wt.sv
// dcache_direct_wt: direct-mapped write-through no-write-allocate data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_direct_wt #(
  parameter int LINES     = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 d_readC,
  input  logic                 d_writeC,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 d_ready,
  output logic                 stall,
  dcache_direct_wt_if.master   mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);
  localparam int IW = $clog2(LINES);
  localparam int TW = WORD_SIZE - 2 - IW;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]           state, nxt;
  logic [LINES-1:0]     valid;
  logic [TW-1:0]        tags  [LINES];
  logic [WORD_SIZE-1:0] words [LINES][4];
  logic [1:0]           offset;
  logic [IW-1:0]        index;
  logic [TW-1:0]        tag;
  logic                 hit, fill_done, write_done, hit_ev, miss_ev;
  assign offset     = address[1:0];
  assign index      = address[2 +: IW];
  assign tag        = address[WORD_SIZE-1 -: TW];
  assign hit        = valid[index] && tags[index] == tag;
  assign fill_done  = state == FILL && mem.mem_ack;
  assign write_done = state == WRITE && mem.mem_ack;
  assign hit_ev     = state == IDLE && d_readC && !d_writeC && hit;
  assign miss_ev    = state == IDLE && nxt == FILL;
  // next state: requests are only sampled in IDLE, writes win over reads
  always_comb
    case (state)
      IDLE:    nxt = d_writeC ? WRITE : (d_readC && !hit) ? FILL : IDLE;
      FILL:    nxt = mem.mem_ack ? RESP : FILL;
      WRITE:   nxt = mem.mem_ack ? IDLE : WRITE;
      default: nxt = IDLE;
    endcase
  // state register and registered memory requests, held until acknowledged
  always_ff @(posedge clk)
    if (!reset_n) begin
      state         <= IDLE;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
    end else begin
      state         <= nxt;
      mem.mem_read  <= nxt == FILL;
      mem.mem_write <= nxt == WRITE;
    end
  // line tags and valid bits; only a completed fill installs a line
  always_ff @(posedge clk)
    if (!reset_n)
      valid <= '0;
    else if (fill_done) begin
      valid[index] <= 1'b1;
      tags[index]  <= tag;
    end
  // line data: whole line on fill, single word on a write hit
  always_ff @(posedge clk)
    if (reset_n && fill_done)
      for (int k = 0; k < 4; k++) words[index][k] <= mem.mem_rdata[k*WORD_SIZE +: WORD_SIZE];
    else if (reset_n && write_done && hit)
      words[index][offset] <= wdata;
  assign d_ready = state == IDLE  ? hit_ev :
                   state == WRITE ? mem.mem_ack :
                   state == RESP  ? d_readC : 1'b0;
  assign rdata   = (d_ready && state != WRITE) ? words[index][offset] : '0;
  assign stall   = (d_readC || d_writeC) && !d_ready;
  assign mem.mem_addr  = mem.mem_write ? address : {address[WORD_SIZE-1:2], 2'b00};
  assign mem.mem_wdata = wdata;
`ifdef DCACHE_STATS_EN
  // saturating read hit / miss counters
  always_ff @(posedge clk)
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_ev && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (miss_ev && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`else
  logic unused_stats;
  assign unused_stats = hit_ev ^ miss_ev;
`endif
endmodule

// File: tb/tb_dcache_direct_wt.sv
// tb_dcache_direct_wt: table vectors, corner sequences and random traffic checked against a residency/memory model
module tb_dcache_direct_wt;
  logic        clk = 0, reset_n = 0, d_readC = 0, d_writeC = 0;
  logic [15:0] address = '0, wdata = '0, rdata;
  logic        d_ready, stall;
  int          n_assert = 0, n_fail = 0;
  int          res [4];
  logic [15:0] bmem [logic [15:0]];
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  dcache_direct_wt_if #(.WORD_SIZE(16)) bus();
  dcache_direct_wt #(.LINES(4), .WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .d_readC(d_readC), .d_writeC(d_writeC),
    .address(address), .wdata(wdata), .rdata(rdata), .d_ready(d_ready),
    .stall(stall), .mem(bus)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rst; bit wr; logic [15:0] addr; logic [15:0] wd; int lat;
    logic [15:0] e_rdata; int e_stall; int e_fill; int e_write; logic [15:0] e_maddr;
  } vec_t;
  vec_t tbl [10];
  function automatic logic [15:0] rd(input logic [15:0] a);
    logic [15:0] h;
    h = a * 16'h9E37;
    return bmem.exists(a) ? bmem[a] : h ^ 16'h5A5A;
  endfunction
  function automatic logic [63:0] line_of(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {rd(b + 16'd3), rd(b + 16'd2), rd(b + 16'd1), rd(b)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 0; d_readC = 0; d_writeC = 0; bus.mem_ack = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    foreach (res[i]) res[i] = -1;
  endtask
  // one pipeline access with memory acking after lat cycles of a held request
  task automatic access(input bit wr, input bit both, input logic [15:0] a, input logic [15:0] d,
                        input int lat, output logic [15:0] got, output int stalls, output int nf,
                        output int nw, output logic [15:0] maddr, output bit to);
    int  busy;
    bit  done;
    d_readC = !wr || both; d_writeC = wr; address = a; wdata = d;
    got = '0; stalls = 0; nf = 0; nw = 0; maddr = '0; busy = 0; done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      #2;
      if (bus.mem_read || bus.mem_write) begin
        busy++;
        maddr = bus.mem_addr;
        if (busy == 1) begin
          if (bus.mem_read) nf++; else nw++;
          if (bus.mem_write) chk("mem_wdata", bus.mem_wdata, d);
        end
        if (busy == lat) begin
          bus.mem_ack = 1;
          bus.mem_rdata = line_of(bus.mem_addr);
          if (bus.mem_write) bmem[bus.mem_addr] = bus.mem_wdata;
        end
      end else busy = 0;
      #1;
      chk("rd_wr_exclusive", bus.mem_read && bus.mem_write, 0);
      if (stall) stalls++;
      if (d_ready) begin got = rdata; done = 1; end
      @(posedge clk);
      #1 bus.mem_ack = 0;
    end
    to = !done;
    d_readC = 0; d_writeC = 0;
  endtask
  // access checked against the model: lines resident per index, data equal to backing memory
  task automatic modeled(input bit wr, input bit both, input logic [15:0] a, input logic [15:0] d, input int lat);
    logic [15:0] got, maddr, expd;
    int st, nf, nw, idx, ln;
    bit to, hit;
    idx = int'(a[3:2]); ln = int'(a[15:2]); hit = res[idx] == ln; expd = rd(a);
    access(wr, both, a, d, lat, got, st, nf, nw, maddr, to);
    chk("timeout", to, 0);
    if (wr) begin
      chk("wr_stall", st, lat); chk("wr_nwrite", nw, 1); chk("wr_nfill", nf, 0); chk("wr_maddr", maddr, a);
    end else begin
      chk("rd_rdata", got, expd);
      chk("rd_stall", st, hit ? 0 : 1 + lat);
      chk("rd_nfill", nf, hit ? 0 : 1);
      if (!hit) chk("rd_maddr", maddr, {a[15:2], 2'b00});
      res[idx] = ln;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] got, maddr;
    int st, nf, nw;
    bit to;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    bmem[16'h0010] = 16'hA; bmem[16'h0011] = 16'hB; bmem[16'h0012] = 16'hC; bmem[16'h0013] = 16'hD;
    tbl[0] = '{1, 0, 16'h0012, 16'h0000, 3, 16'h000C, 4, 1, 0, 16'h0010};
    tbl[1] = '{0, 0, 16'h0013, 16'h0000, 3, 16'h000D, 0, 0, 0, 16'h0000};
    tbl[2] = '{0, 1, 16'h0011, 16'h55AA, 2, 16'h0000, 2, 0, 1, 16'h0011};
    tbl[3] = '{0, 0, 16'h0011, 16'h0000, 2, 16'h55AA, 0, 0, 0, 16'h0000};
    tbl[4] = '{1, 1, 16'h0050, 16'h1234, 1, 16'h0000, 1, 0, 1, 16'h0050};
    tbl[5] = '{0, 0, 16'h0010, 16'h0000, 2, 16'h000A, 3, 1, 0, 16'h0010};
    tbl[6] = '{0, 0, 16'h0050, 16'h0000, 2, 16'h1234, 3, 1, 0, 16'h0050};
    tbl[7] = '{0, 0, 16'h0012, 16'h0000, 1, 16'h000C, 2, 1, 0, 16'h0010};
    tbl[8] = '{0, 1, 16'h0013, 16'hBEEF, 4, 16'h0000, 4, 0, 1, 16'h0013};
    tbl[9] = '{0, 0, 16'h0013, 16'h0000, 1, 16'hBEEF, 0, 0, 0, 16'h0000};
    do_reset();
    #2;
    chk("rst_d_ready", d_ready, 0); chk("rst_rdata", rdata, 0); chk("rst_stall", stall, 0);
    chk("rst_mem_read", bus.mem_read, 0); chk("rst_mem_write", bus.mem_write, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      access(tbl[i].wr, 0, tbl[i].addr, tbl[i].wd, tbl[i].lat, got, st, nf, nw, maddr, to);
      chk($sformatf("tbl%0d_timeout", i), to, 0);
      chk($sformatf("tbl%0d_stall", i), st, tbl[i].e_stall);
      chk($sformatf("tbl%0d_nfill", i), nf, tbl[i].e_fill);
      chk($sformatf("tbl%0d_nwrite", i), nw, tbl[i].e_write);
      if (tbl[i].e_fill + tbl[i].e_write > 0) chk($sformatf("tbl%0d_maddr", i), maddr, tbl[i].e_maddr);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), got, tbl[i].e_rdata);
    end
    do_reset();
    modeled(0, 0, 16'h0012, 16'h0, 2);
    modeled(0, 0, 16'h0013, 16'h0, 1);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_pre", hit_count, 1); chk("stats_miss_pre", miss_count, 1);
`endif
    d_readC = 1; address = 16'h0040;
    @(posedge clk); #1;
    chk("midfill_started", bus.mem_read, 1);
    reset_n = 0; d_readC = 0; bus.mem_ack = 1; bus.mem_rdata = 64'hDEAD_BEEF_F00D_CAFE;
    @(posedge clk); #1;
    chk("midfill_rst_mem_read", bus.mem_read, 0);
    reset_n = 1;
    @(posedge clk); #1;
    bus.mem_ack = 0;
    #1;
    chk("late_ack_mem_read", bus.mem_read, 0); chk("late_ack_d_ready", d_ready, 0);
    foreach (res[i]) res[i] = -1;
`ifdef DCACHE_STATS_EN
    chk("stats_hit_rst", hit_count, 0); chk("stats_miss_rst", miss_count, 0);
`endif
    @(posedge clk); #1;
    modeled(0, 0, 16'h0040, 16'h0, 2);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_post", hit_count, 0); chk("stats_miss_post", miss_count, 1);
`endif
    d_readC = 1; address = 16'h0024;
    @(posedge clk); #1;
    chk("drop_fill_started", bus.mem_read, 1);
    d_readC = 0;
    @(posedge clk); #1;
    bus.mem_ack = 1; bus.mem_rdata = line_of(16'h0024);
    #1 chk("drop_fill_ready", d_ready, 0);
    @(posedge clk); #1;
    bus.mem_ack = 0;
    #1;
    chk("drop_resp_ready", d_ready, 0); chk("drop_resp_rdata", rdata, 0); chk("drop_resp_mem_read", bus.mem_read, 0);
    @(posedge clk); #1;
    res[1] = 9;
    bus.mem_ack = 1; bus.mem_rdata = '1;
    @(posedge clk); #1;
    bus.mem_ack = 0;
    modeled(0, 0, 16'h0025, 16'h0, 3);
    modeled(1, 1, 16'h0026, 16'h7777, 2);
    modeled(0, 0, 16'h0026, 16'h0, 1);
    do_reset();
    for (int i = 0; i < 300; i++)
      modeled($urandom_range(0, 2) == 0, 0, 16'($urandom_range(0, 127)), 16'($urandom), $urandom_range(1, 4));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
